// File: rtl/alu_exec_unit.sv
// alu_exec_unit: two-stage pipelined integer ALU with valid/ready handshakes on
// both sides.
// Stage S1 captures the opcode, operands and tag. Stage S2 holds the computed
// result, its zero flag, the tag and the illegal-opcode flag.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operation offered this cycle
//   in_ready     operation accepted this cycle (combinational)
//   alu_control  opcode: 000 add, 001 sub, 010 and, 011 or, 101 slt
//   src_a/src_b  operands, XLEN bits
//   rd_in        destination register tag
//   flush        kill every in-flight operation
//   out_valid    result available
//   out_ready    consumer takes the result this cycle
//   result       operation result
//   zero         result equals 0
//   rd_out       tag of the operation shown on result
//   illegal_op   opcode was an unassigned code (100, 110, 111)
module alu_exec_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [4:0]      rd_out,
  output logic            illegal_op
);

  // Stage 1 state
  logic            s1_valid_q;
  logic [2:0]      s1_ctrl_q;
  logic [XLEN-1:0] s1_a_q;
  logic [XLEN-1:0] s1_b_q;
  logic [4:0]      s1_rd_q;

  // Stage 2 state
  logic            s2_valid_q;
  logic [XLEN-1:0] s2_result_q;
  logic            s2_zero_q;
  logic [4:0]      s2_rd_q;
  logic            s2_illegal_q;

  logic            s2_advance;
  logic            s1_advance;
  logic            in_fire;
  logic            s2_load;
  logic [XLEN-1:0] alu_res;
  logic            alu_illegal;

  // S2 can take a new entry when it is empty or its current entry leaves.
  // S1 can take a new entry when it is empty or its entry moves into S2.
  assign s2_advance = !s2_valid_q || out_ready;
  assign s1_advance = !s1_valid_q || s2_advance;
  // rst gating keeps in_ready low during reset even though the datapath ignores it.
  assign in_ready   = !rst && !flush && s1_advance;
  assign in_fire    = in_valid && in_ready;
  assign s2_load    = !flush && s2_advance && s1_valid_q;

  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (s1_ctrl_q)
      3'b000:  alu_res = s1_a_q + s1_b_q;
      3'b001:  alu_res = s1_a_q - s1_b_q;
      3'b010:  alu_res = s1_a_q & s1_b_q;
      3'b011:  alu_res = s1_a_q | s1_b_q;
      3'b101:  alu_res = {{(XLEN-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
      default: alu_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_ctrl_q    <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_rd_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_zero_q    <= 1'b0;
      s2_rd_q      <= '0;
      s2_illegal_q <= 1'b0;
    end else begin
      if (flush) begin
        // A concurrent out_ready is not a transfer: the entry is simply dropped.
        s1_valid_q <= 1'b0;
        s2_valid_q <= 1'b0;
      end else begin
        if (s1_advance) s1_valid_q <= in_fire;
        if (s2_advance) s2_valid_q <= s1_valid_q;
      end
      if (in_fire) begin
        s1_ctrl_q <= alu_control;
        s1_a_q    <= src_a;
        s1_b_q    <= src_b;
        s1_rd_q   <= rd_in;
      end
      // Data only moves on a real load so a stalled result stays stable.
      if (s2_load) begin
        s2_result_q  <= alu_res;
        s2_zero_q    <= (alu_res == '0);
        s2_rd_q      <= s1_rd_q;
        s2_illegal_q <= alu_illegal;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign result     = s2_result_q;
  assign zero       = s2_zero_q;
  assign rd_out     = s2_rd_q;
  assign illegal_op = s2_illegal_q;

endmodule
